// File: rtl/param_seq_detector_if.sv
// Serial-bit input and match/display output bundle for param_seq_detector.
// Handshake: bit_in is consumed on every rising edge where bit_valid=1 (no backpressure, no ready); clear is a one-cycle synchronous strobe that wins over bit_valid.
interface param_seq_detector_if;
  logic        bit_in;
  logic        bit_valid;
  logic        clear;
  logic        match_pulse;
  logic [13:0] match_count;
  logic [3:0]  Anode_Activate;
  logic [6:0]  LED_out;

  modport master (
    output bit_in, bit_valid, clear,
    input  match_pulse, match_count, Anode_Activate, LED_out
  );

  modport slave (
    input  bit_in, bit_valid, clear,
    output match_pulse, match_count, Anode_Activate, LED_out
  );
endinterface

// File: rtl/param_seq_detector.sv
// Serial pattern detector with saturating match counter and optional 4-digit 7-segment display.
// Display logic is compiled in only when SEQ_DET_DISPLAY_EN is defined; otherwise all segments/anodes stay dark.
module param_seq_detector #(
  parameter int          PAT_LEN   = 4,
  parameter logic [15:0] PATTERN   = 16'h000B,
  parameter int          OVERLAP   = 1,
  parameter int          REFRESH_W = 20
) (
  input  logic                 clock_100Mhz,
  input  logic                 reset,
  param_seq_detector_if.slave  bus
);
  localparam logic [4:0]  FILL_FULL = 5'(PAT_LEN);
  localparam logic [4:0]  FILL_NEAR = 5'(PAT_LEN - 1);
  localparam logic [13:0] CNT_MAX   = 14'd9999;

  logic [PAT_LEN-1:0] hist;
  logic [PAT_LEN-1:0] hist_next;
  logic [4:0]         fill;
  logic [13:0]        count;
  logic               pulse;
  logic               hit;
  logic               count_inc;

  assign hist_next = {hist[PAT_LEN-2:0], bus.bit_in};
  assign hit       = bus.bit_valid && (fill >= FILL_NEAR) && (hist_next == PATTERN[PAT_LEN-1:0]);
  // Count saturates at 9999 but the pulse still reports every match.
  assign count_inc = hit && (count != CNT_MAX);

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      hist  <= '0;
      fill  <= '0;
      count <= '0;
      pulse <= 1'b0;
    end else if (bus.clear) begin
      hist  <= '0;
      fill  <= '0;
      count <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= hit;
      if (bus.bit_valid) begin
        if (hit && (OVERLAP == 0)) begin
          hist <= '0;
          fill <= '0;
        end else begin
          hist <= hist_next;
          if (fill != FILL_FULL) fill <= fill + 5'd1;
        end
      end
      if (count_inc) count <= count + 14'd1;
    end
  end

  assign bus.match_pulse = pulse;
  assign bus.match_count = count;

`ifdef SEQ_DET_DISPLAY_EN
  logic [REFRESH_W-1:0] refresh;
  logic [3:0][3:0]      bcd;
  logic [3:0][3:0]      bcd_next;
  logic                 carry;
  logic [1:0]           phase;
  logic [3:0]           digit;

  // Decimal ripple increment keeps the digits in step with count without a divider.
  always_comb begin
    bcd_next = bcd;
    carry    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (bcd[i] == 4'd9) begin
          bcd_next[i] = 4'd0;
        end else begin
          bcd_next[i] = bcd[i] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      refresh <= '0;
      bcd     <= '0;
    end else begin
      refresh <= refresh + 1'b1;
      if (bus.clear)      bcd <= '0;
      else if (count_inc) bcd <= bcd_next;
    end
  end

  assign phase = refresh[REFRESH_W-1 -: 2];

  always_comb begin
    bus.Anode_Activate = 4'b0111;
    digit              = bcd[3];
    case (phase)
      2'd0: begin bus.Anode_Activate = 4'b0111; digit = bcd[3]; end
      2'd1: begin bus.Anode_Activate = 4'b1011; digit = bcd[2]; end
      2'd2: begin bus.Anode_Activate = 4'b1101; digit = bcd[1]; end
      default: begin bus.Anode_Activate = 4'b1110; digit = bcd[0]; end
    endcase
  end

  always_comb begin
    bus.LED_out = 7'b0000001;
    case (digit)
      4'd0: bus.LED_out = 7'b0000001;
      4'd1: bus.LED_out = 7'b1001111;
      4'd2: bus.LED_out = 7'b0010010;
      4'd3: bus.LED_out = 7'b0000110;
      4'd4: bus.LED_out = 7'b1001100;
      4'd5: bus.LED_out = 7'b0100100;
      4'd6: bus.LED_out = 7'b0100000;
      4'd7: bus.LED_out = 7'b0001111;
      4'd8: bus.LED_out = 7'b0000000;
      4'd9: bus.LED_out = 7'b0000100;
      default: bus.LED_out = 7'b0000001;
    endcase
  end
`else
  assign bus.Anode_Activate = 4'b1111;
  assign bus.LED_out        = 7'b1111111;
`endif
endmodule

// File: tb/tb_param_seq_detector.sv
// Bench for param_seq_detector: four parameter sets share one stimulus stream and are checked every cycle against a bit-history model.
module tb_param_seq_detector;
  localparam int NCFG = 4;
  localparam int RW   = 6;
  localparam int P_LEN [NCFG] = '{4, 3, 4, 3};
  localparam int P_PAT [NCFG] = '{11, 7, 11, 7};
  localparam int P_OV  [NCFG] = '{1, 1, 0, 0};

  logic clock_100Mhz = 1'b0;
  logic reset = 1'b1;
  logic bit_in = 1'b0;
  logic bit_valid = 1'b0;
  logic clear = 1'b0;

  logic        pulse_o [NCFG];
  logic [13:0] cnt_o   [NCFG];
  logic [3:0]  an_o    [NCFG];
  logic [6:0]  led_o   [NCFG];

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: bits received since the last reset/clear/non-overlapping match.
  logic [31:0] seen_val [NCFG];
  int          seen_n   [NCFG];
  int          exp_cnt  [NCFG];
  logic        exp_pulse[NCFG];
  int          exp_ref;

  always #5 clock_100Mhz = ~clock_100Mhz;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    param_seq_detector_if bus();
    assign bus.bit_in    = bit_in;
    assign bus.bit_valid = bit_valid;
    assign bus.clear     = clear;
    param_seq_detector #(
      .PAT_LEN(P_LEN[g]), .PATTERN(16'(P_PAT[g])), .OVERLAP(P_OV[g]), .REFRESH_W(RW)
    ) dut (
      .clock_100Mhz(clock_100Mhz),
      .reset(reset),
      .bus(bus)
    );
    assign pulse_o[g] = bus.match_pulse;
    assign cnt_o[g]   = bus.match_count;
    assign an_o[g]    = bus.Anode_Activate;
    assign led_o[g]   = bus.LED_out;
  end

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: seg = 7'b0000001;
      1: seg = 7'b1001111;
      2: seg = 7'b0010010;
      3: seg = 7'b0000110;
      4: seg = 7'b1001100;
      5: seg = 7'b0100100;
      6: seg = 7'b0100000;
      7: seg = 7'b0001111;
      8: seg = 7'b0000000;
      9: seg = 7'b0000100;
      default: seg = 7'b0000001;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model, advanced on the same edges as the DUT.
  always @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      exp_ref = 0;
      for (int c = 0; c < NCFG; c++) begin
        seen_val[c] = 0; seen_n[c] = 0; exp_cnt[c] = 0; exp_pulse[c] = 1'b0;
      end
    end else begin
      exp_ref = (exp_ref + 1) % (1 << RW);
      for (int c = 0; c < NCFG; c++) begin
        if (clear) begin
          seen_val[c] = 0; seen_n[c] = 0; exp_cnt[c] = 0; exp_pulse[c] = 1'b0;
        end else begin
          logic m;
          m = 1'b0;
          if (bit_valid) begin
            seen_val[c] = {seen_val[c][30:0], bit_in};
            seen_n[c]++;
            if (seen_n[c] >= P_LEN[c] && (seen_val[c] & ((32'd1 << P_LEN[c]) - 1)) == 32'(P_PAT[c])) m = 1'b1;
            if (m && P_OV[c] == 0) begin
              seen_val[c] = 0; seen_n[c] = 0;
            end
          end
          exp_pulse[c] = m;
          if (m && exp_cnt[c] < 9999) exp_cnt[c]++;
        end
      end
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clock_100Mhz) begin
    if (!reset) begin
      for (int c = 0; c < NCFG; c++) begin
        int ph, dg, v;
        check($sformatf("cfg%0d pulse", c), int'(pulse_o[c]), int'(exp_pulse[c]));
        check($sformatf("cfg%0d count", c), int'(cnt_o[c]), exp_cnt[c]);
        ph = (exp_ref >> (RW - 2)) & 3;
        v  = exp_cnt[c];
        dg = (ph == 0) ? v / 1000 : (ph == 1) ? (v / 100) % 10 : (ph == 2) ? (v / 10) % 10 : v % 10;
`ifdef SEQ_DET_DISPLAY_EN
        check($sformatf("cfg%0d anode", c), int'(an_o[c]), int'(~(4'b1000 >> ph) & 4'hF));
        check($sformatf("cfg%0d led", c), int'(led_o[c]), int'(seg(dg)));
`else
        check($sformatf("cfg%0d anode", c), int'(an_o[c]), 15);
        check($sformatf("cfg%0d led", c), int'(led_o[c]), 127);
        if (dg < 0) check("digit", dg, 0);
`endif
      end
    end
  end

  task automatic tick(input logic b, input logic v, input logic c);
    bit_in = b; bit_valid = v; clear = c;
    @(negedge clock_100Mhz);
  endtask

  task automatic do_reset();
    bit_in = 1'b0; bit_valid = 1'b0; clear = 1'b0;
    @(negedge clock_100Mhz);
    #2 reset = 1'b1;
    #1 check("async reset count", int'(cnt_o[0]), 0);
    check("async reset pulse", int'(pulse_o[0]), 0);
    @(negedge clock_100Mhz);
    #2 reset = 1'b0;
    @(negedge clock_100Mhz);
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      tick(bits[i], 1'b1, 1'b0);
      if (i != 0) repeat (gap) tick(1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    #23 reset = 1'b0;
    @(negedge clock_100Mhz);
    check("post-reset count", int'(cnt_o[0]), 0);
`ifdef SEQ_DET_DISPLAY_EN
    check("post-reset anode", int'(an_o[0]), 4'b0111);
    check("post-reset led", int'(led_o[0]), 7'b0000001);
`endif

    // Basic 1011 detection and pulse timing.
    send_bits(32'b1011, 4, 0);
    check("1011 pulse", int'(pulse_o[0]), 1);
    check("1011 count", int'(cnt_o[0]), 1);
`ifndef SEQ_DET_DISPLAY_EN
    check("dark anode", int'(an_o[0]), 4'b1111);
    check("dark led", int'(led_o[0]), 7'b1111111);
`endif
    tick(1'b0, 1'b0, 1'b0);
    check("1011 pulse drop", int'(pulse_o[0]), 0);

    do_reset();
    send_bits(32'b1011011, 7, 0);
    check("1011011 overlap count", int'(cnt_o[0]), 2);

    do_reset();
    send_bits(32'b101011, 6, 0);
    check("101011 count", int'(cnt_o[0]), 1);

    do_reset();
    send_bits(32'b10111011, 8, 0);
    check("10111011 nonoverlap count", int'(cnt_o[2]), 2);

    do_reset();
    send_bits(32'b11111, 5, 0);
    check("111 overlap count", int'(cnt_o[1]), 3);
    check("111 nonoverlap count", int'(cnt_o[3]), 1);

    do_reset();
    send_bits(32'b1011, 4, 5);
    check("gapped count", int'(cnt_o[0]), 1);

    do_reset();
    send_bits(32'b101, 3, 0);
    tick(1'b1, 1'b1, 1'b1);
    check("clear count", int'(cnt_o[0]), 0);
    check("clear pulse", int'(pulse_o[0]), 0);
    tick(1'b0, 1'b0, 1'b0);
    check("clear pulse after", int'(pulse_o[0]), 0);

    // Random traffic with sparse clears.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 199) == 0));
    end

    // Saturation: 1 then (0,1,1)x10002 gives 10002 matches of 1011.
    do_reset();
    tick(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 10002; k++) begin
      tick(1'b0, 1'b1, 1'b0);
      tick(1'b1, 1'b1, 1'b0);
      tick(1'b1, 1'b1, 1'b0);
    end
    check("saturated count", int'(cnt_o[0]), 9999);
    for (int k = 0; k < 70; k++) begin
      tick(1'b0, 1'b0, 1'b0);
`ifdef SEQ_DET_DISPLAY_EN
      check("saturated led", int'(led_o[0]), 7'b0000100);
`endif
    end

    // Reset in the middle of a partial pattern.
    send_bits(32'b101, 3, 0);
    do_reset();
    check("mid reset count", int'(cnt_o[0]), 0);
`ifdef SEQ_DET_DISPLAY_EN
    check("mid reset led", int'(led_o[0]), 7'b0000001);
`endif
    send_bits(32'b1, 1, 0);
    check("partial discarded", int'(cnt_o[0]), 0);

    repeat (3) tick(1'b0, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
